// File: rtl/flash_bus_perf_mon.sv
// Flash bus performance monitor: per-tag latency tracking,
// error/anomaly counters and a freezable debug snapshot.
module flash_bus_perf_mon #(
  parameter int TAG_W = 3
) (
  input  logic             v_clk0,
  input  logic             v_rst0,
  input  logic             cmd_valid,
  input  logic             cmd_ready,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic             done_valid,
  input  logic [TAG_W-1:0] done_tag,
  input  logic             done_err,
  input  logic             ctrl_freeze,
  input  logic             ctrl_clear,
  output logic [15:0]      dbg_cmd_cnt,
  output logic [15:0]      dbg_ctrl_state,
  output logic [63:0]      dbg_latency_64,
  output logic [63:0]      dbg_err_64
);

  localparam int N = 1 << TAG_W;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_SPARE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   clear_q;

  logic [31:0]  ts_q;
  logic [31:0]  start_q [N];
  logic [N-1:0] pend_q, pend_d;
  logic [15:0]  cmd_q, cmd_d;
  logic [15:0]  out_q, out_d;
  logic [31:0]  max_q, max_d;
  logic [31:0]  last_q, last_d;
  logic [31:0]  ecc_q, ecc_d;
  logic [31:0]  anom_q, anom_d;

  logic [15:0]  dbg_cmd_q;
  logic [3:0]   dbg_out_q;
  logic [31:0]  dbg_max_q, dbg_last_q;
  logic [31:0]  dbg_ecc_q, dbg_anom_q;

  logic        clear_rise;
  logic        active;
  logic        issue, done;
  logic        done_hit, done_miss;
  logic        same_tag, dup;
  logic        inc;
  logic [31:0] lat;

  function automatic logic [31:0] sat32(
    input logic [31:0] a,
    input logic [1:0]  b
  );
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [15:0] sat16(
    input logic [15:0] a
  );
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  assign clear_rise = ctrl_clear & ~clear_q;

  // Control FSM next-state: clear pulse wins over freeze level
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (clear_rise)       state_d = ST_CLEAR;
        else if (ctrl_freeze) state_d = ST_FREEZE;
      end
      ST_FREEZE: begin
        if (clear_rise)        state_d = ST_CLEAR;
        else if (!ctrl_freeze) state_d = ST_RUN;
      end
      ST_CLEAR: begin
        state_d = ctrl_freeze ? ST_FREEZE : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign active    = (state_q != ST_CLEAR);
  assign issue     = active & cmd_valid & cmd_ready;
  assign done      = active & done_valid;
  assign done_hit  = done & pend_q[done_tag];
  assign done_miss = done & ~pend_q[done_tag];
  assign same_tag  = (done_tag == cmd_tag);
  // A completion on the same tag retires first, so re-issue is clean
  assign dup       = issue & pend_q[cmd_tag] & ~(done_hit & same_tag);
  assign inc       = issue & ~dup;
  assign lat       = ts_q - start_q[done_tag];

  // Tracking next-state: completion applied before issue
  always_comb begin
    pend_d = pend_q;
    cmd_d  = cmd_q;
    out_d  = out_q;
    max_d  = max_q;
    last_d = last_q;
    ecc_d  = ecc_q;
    anom_d = anom_q;
    if (done_hit) begin
      pend_d[done_tag] = 1'b0;
      last_d = lat;
      if (lat > max_q) max_d = lat;
    end
    if (issue) begin
      pend_d[cmd_tag] = 1'b1;
      cmd_d = sat16(cmd_q);
    end
    unique case (1'b1)
      (inc & ~done_hit): out_d = sat16(out_q);
      (~inc & done_hit): begin
        if (out_q != 16'd0) out_d = out_q - 16'd1;
      end
      default: out_d = out_q;
    endcase
    anom_d = sat32(anom_q, {1'b0, dup} + {1'b0, done_miss});
    if (done & done_err) ecc_d = sat32(ecc_q, 2'd1);
    if (state_q == ST_CLEAR) begin
      pend_d = '0;
      cmd_d  = '0;
      out_d  = '0;
      max_d  = '0;
      last_d = '0;
      ecc_d  = '0;
      anom_d = '0;
    end
  end

  // State, timestamp and tracking registers
  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      state_q <= ST_RUN;
      clear_q <= 1'b0;
      ts_q    <= '0;
      pend_q  <= '0;
      cmd_q   <= '0;
      out_q   <= '0;
      max_q   <= '0;
      last_q  <= '0;
      ecc_q   <= '0;
      anom_q  <= '0;
    end else begin
      state_q <= state_d;
      clear_q <= ctrl_clear;
      ts_q    <= ts_q + 32'd1;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      out_q   <= out_d;
      max_q   <= max_d;
      last_q  <= last_d;
      ecc_q   <= ecc_d;
      anom_q  <= anom_d;
    end
  end

  // Start timestamps; only meaningful while the pend bit is set
  always_ff @(posedge v_clk0) begin
    if (issue) start_q[cmd_tag] <= ts_q;
  end

  // Debug snapshot: follows live values except while frozen
  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      dbg_cmd_q  <= '0;
      dbg_out_q  <= '0;
      dbg_max_q  <= '0;
      dbg_last_q <= '0;
      dbg_ecc_q  <= '0;
      dbg_anom_q <= '0;
    end else if (state_q != ST_FREEZE) begin
      dbg_cmd_q  <= cmd_d;
      dbg_out_q  <= (out_d > 16'd15) ? 4'hF : out_d[3:0];
      dbg_max_q  <= max_d;
      dbg_last_q <= last_d;
      dbg_ecc_q  <= ecc_d;
      dbg_anom_q <= anom_d;
    end
  end

  assign dbg_cmd_cnt    = dbg_cmd_q;
  assign dbg_ctrl_state = {8'h00, dbg_out_q, 2'b00, state_q};
  assign dbg_latency_64 = {dbg_max_q, dbg_last_q};
  assign dbg_err_64     = {dbg_ecc_q, dbg_anom_q};

endmodule

// File: tb/tb_flash_bus_perf_mon.sv
// Directed bench for flash_bus_perf_mon with an
// expected-value queue drained after each stimulus step.
module tb_flash_bus_perf_mon;

  logic        v_clk0 = 1'b0;
  logic        v_rst0 = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready = 1'b0;
  logic [2:0]  cmd_tag = '0;
  logic        done_valid = 1'b0;
  logic [2:0]  done_tag = '0;
  logic        done_err = 1'b0;
  logic        ctrl_freeze = 1'b0;
  logic        ctrl_clear = 1'b0;
  logic [15:0] dbg_cmd_cnt;
  logic [15:0] dbg_ctrl_state;
  logic [63:0] dbg_latency_64;
  logic [63:0] dbg_err_64;

  flash_bus_perf_mon #(.TAG_W(3)) dut (
    .v_clk0         (v_clk0),
    .v_rst0         (v_rst0),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_tag        (cmd_tag),
    .done_valid     (done_valid),
    .done_tag       (done_tag),
    .done_err       (done_err),
    .ctrl_freeze    (ctrl_freeze),
    .ctrl_clear     (ctrl_clear),
    .dbg_cmd_cnt    (dbg_cmd_cnt),
    .dbg_ctrl_state (dbg_ctrl_state),
    .dbg_latency_64 (dbg_latency_64),
    .dbg_err_64     (dbg_err_64)
  );

  always #5 v_clk0 = ~v_clk0;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] v;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] now    = '0;

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      0:       return {48'd0, dbg_cmd_cnt};
      1:       return {48'd0, dbg_ctrl_state};
      2:       return dbg_latency_64;
      default: return dbg_err_64;
    endcase
  endfunction

  task automatic push(input string n, input int s, input logic [63:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.v    = v;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t        e;
    logic [63:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      n_chk++;
      assert (o === e.v) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", e.name, o, e.v);
    end
  endtask

  task automatic tick();
    @(posedge v_clk0);
    @(negedge v_clk0);
    if (v_rst0) now = '0;
    else now = now + 32'd1;
  endtask

  task automatic idle();
    cmd_valid  = 1'b0;
    cmd_ready  = 1'b0;
    done_valid = 1'b0;
    done_err   = 1'b0;
  endtask

  task automatic run_to(input logic [31:0] t);
    int n;
    n = 0;
    idle();
    while (now != t && n < 1000) begin
      tick();
      n++;
    end
    if (now != t) begin
      n_chk++;
      $error("FAIL run_to observed=%h expected=%h", now, t);
    end
  endtask

  task automatic issue(input logic [2:0] t);
    cmd_valid = 1'b1;
    cmd_ready = 1'b1;
    cmd_tag   = t;
  endtask

  task automatic complete(input logic [2:0] t, input logic e);
    done_valid = 1'b1;
    done_tag   = t;
    done_err   = e;
  endtask

  initial begin
    @(negedge v_clk0);
    repeat (3) tick();
    push("rst_cmd", 0, 64'd0);
    push("rst_state", 1, 64'd0);
    push("rst_lat", 2, 64'd0);
    push("rst_err", 3, 64'd0);
    chk();
    v_rst0 = 1'b0;

    run_to(32'd10);
    issue(3'd2);
    tick();
    idle();
    push("iss2_cmd", 0, 64'd1);
    push("iss2_out", 1, 64'h10);
    chk();

    run_to(32'd35);
    complete(3'd2, 1'b0);
    tick();
    idle();
    push("lat25", 2, {32'd25, 32'd25});
    push("lat25_out", 1, 64'h0);
    push("lat25_cmd", 0, 64'd1);
    chk();

    complete(3'd5, 1'b1);
    tick();
    idle();
    push("orphan_err", 3, {32'd1, 32'd1});
    push("orphan_lat", 2, {32'd25, 32'd25});
    push("orphan_out", 1, 64'h0);
    chk();

    run_to(32'd100);
    issue(3'd1);
    tick();
    run_to(32'd140);
    issue(3'd1);
    complete(3'd1, 1'b0);
    tick();
    idle();
    push("same_lat", 2, {32'd40, 32'd40});
    push("same_out", 1, 64'h10);
    push("same_cmd", 0, 64'd3);
    push("same_err", 3, {32'd1, 32'd1});
    chk();

    run_to(32'd150);
    complete(3'd1, 1'b0);
    tick();
    idle();
    push("rearm_lat", 2, {32'd40, 32'd10});
    push("rearm_out", 1, 64'h0);
    push("rearm_err", 3, {32'd1, 32'd1});
    chk();

    run_to(32'd160);
    issue(3'd3);
    tick();
    run_to(32'd177);
    issue(3'd4);
    complete(3'd3, 1'b0);
    tick();
    idle();
    push("diff_lat", 2, {32'd40, 32'd17});
    push("diff_out", 1, 64'h10);
    push("diff_cmd", 0, 64'd5);
    chk();

    issue(3'd4);
    tick();
    idle();
    push("dup_err", 3, {32'd1, 32'd2});
    push("dup_out", 1, 64'h10);
    push("dup_cmd", 0, 64'd6);
    chk();

    ctrl_freeze = 1'b1;
    tick();
    push("frz_state", 1, 64'h11);
    push("frz_cmd", 0, 64'd6);
    chk();
    for (int i = 5; i < 8; i++) begin
      issue(3'(i));
      tick();
      idle();
      push("frz_hold_cmd", 0, 64'd6);
      push("frz_hold_state", 1, 64'h11);
      chk();
    end
    ctrl_freeze = 1'b0;
    tick();
    push("unfrz_cmd", 0, 64'd6);
    push("unfrz_state", 1, 64'h10);
    chk();
    tick();
    push("run_cmd", 0, 64'd9);
    push("run_state", 1, 64'h40);
    chk();

    for (int i = 0; i < 4; i++) begin
      issue(3'(i));
      tick();
    end
    idle();
    push("full_cmd", 0, 64'd13);
    push("full_state", 1, 64'h80);
    chk();

    ctrl_clear = 1'b1;
    tick();
    push("clr_state", 1, 64'h82);
    push("clr_cmd", 0, 64'd13);
    chk();
    issue(3'd0);
    complete(3'd1, 1'b1);
    tick();
    idle();
    push("post_clr_cmd", 0, 64'd0);
    push("post_clr_state", 1, 64'h0);
    push("post_clr_lat", 2, 64'd0);
    push("post_clr_err", 3, 64'd0);
    chk();
    ctrl_clear = 1'b0;
    complete(3'd0, 1'b0);
    tick();
    idle();
    push("clr_anom_err", 3, {32'd0, 32'd1});
    push("clr_anom_lat", 2, 64'd0);
    push("clr_anom_state", 1, 64'h0);
    chk();

    issue(3'd6);
    tick();
    idle();
    push("pre_rst_state", 1, 64'h10);
    chk();
    v_rst0 = 1'b1;
    tick();
    v_rst0 = 1'b0;
    push("mid_rst_state", 1, 64'h0);
    push("mid_rst_err", 3, 64'd0);
    push("mid_rst_cmd", 0, 64'd0);
    chk();
    complete(3'd6, 1'b0);
    tick();
    idle();
    push("rst_anom_err", 3, {32'd0, 32'd1});
    push("rst_anom_state", 1, 64'h0);
    chk();

    force dut.ts_q = 32'hFFFF_FFF0;
    #1;
    release dut.ts_q;
    now = 32'hFFFF_FFF0;
    issue(3'd2);
    tick();
    run_to(32'h10);
    complete(3'd2, 1'b0);
    tick();
    idle();
    push("wrap_lat", 2, {32'h20, 32'h20});
    push("wrap_cmd", 0, 64'd1);
    push("wrap_state", 1, 64'h0);
    chk();

    issue(3'd3);
    repeat (65540) tick();
    idle();
    push("sat_cmd", 0, 64'hFFFF);
    push("sat_state", 1, 64'h10);
    chk();
    issue(3'd3);
    tick();
    idle();
    push("sat_hold_cmd", 0, 64'hFFFF);
    chk();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_bus_perf_mon.md
FLASH_BUS_PERF_MON -- requirements
Module: flash_bus_perf_mon

Interface
REQ-001 SHALL have parameter TAG_W, default 3, tag width; the tracking table has 2^TAG_W entries.
REQ-002 SHALL have port v_clk0, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port v_rst0, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid, input, 1 bit: bus controller command valid.
REQ-005 SHALL have port cmd_ready, input, 1 bit: bus controller command ready; the block only observes this handshake and never drives it.
REQ-006 SHALL have port cmd_tag, input, TAG_W bits: tag of the issued command.
REQ-007 SHALL have port done_valid, input, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port done_tag, input, TAG_W bits: tag of the completed command.
REQ-009 SHALL have port done_err, input, 1 bit: the completion carried an uncorrectable ECC error.
REQ-010 SHALL have port ctrl_freeze, input, 1 bit: level from VIO; while high, the dbg_* outputs are held.
REQ-011 SHALL have port ctrl_clear, input, 1 bit: clear request from VIO; acts on its rising edge.
REQ-012 SHALL have port dbg_cmd_cnt, output, 16 bits: count of accepted commands.
REQ-013 SHALL have port dbg_ctrl_state, output, 16 bits: [1:0] FSM state, [7:4] outstanding count, all other bits 0.
REQ-014 SHALL have port dbg_latency_64, output, 64 bits: [63:32] maximum latency, [31:0] last latency.
REQ-015 SHALL have port dbg_err_64, output, 64 bits: [63:32] ECC error count, [31:0] protocol anomaly count.

Function
REQ-016 SHALL run a free-running 32-bit timestamp counter that increments every cycle and wraps; latency is (ts - start) mod 2^32.
REQ-017 SHALL treat an issue as cmd_valid & cmd_ready in a cycle; on an issue it stores start[cmd_tag]=ts, sets pend[cmd_tag], and increments the outstanding count.
REQ-018 SHALL, on an issue to a tag already pending, increment the anomaly count, overwrite the timestamp, and leave the outstanding count unchanged.
REQ-019 SHALL, on done_valid to a pending tag, compute latency = ts - start[done_tag], load it into last latency, update max latency when latency > max, clear pend, and decrement the outstanding count.
REQ-020 SHALL, on done_valid to a tag that is not pending, increment the anomaly count and leave latency and the outstanding count unchanged.
REQ-021 SHALL increment the ECC error count on done_valid & done_err, whether or not the tag is pending.
REQ-022 SHALL, when an issue and a completion occur in the same cycle on the same tag, process the completion first using the old start value, then re-arm pend/start; the outstanding count is unchanged.
REQ-023 SHALL, when an issue and a completion occur in the same cycle on different tags, apply both; the outstanding count is unchanged.
REQ-024 SHALL increment dbg_cmd_cnt on every issue, including duplicates.
REQ-025 SHALL make every counter saturate at all-ones and never wrap.
REQ-026 SHALL have FSM states RUN=0, FREEZE=1, CLEAR=2; state 3 is unused and recovers to RUN.
REQ-027 SHALL, on a ctrl_clear rising edge in RUN or FREEZE, go to CLEAR for exactly one cycle.
REQ-028 SHALL, in CLEAR, zero all counters, max/last latency, and pend; issues and completions in that cycle are ignored; the timestamp counter is not cleared.
REQ-029 SHALL leave CLEAR for FREEZE if ctrl_freeze=1, otherwise for RUN.
REQ-030 SHALL go from RUN to FREEZE when ctrl_freeze=1, and from FREEZE to RUN when ctrl_freeze=0.
REQ-031 SHALL keep internal tracking running in FREEZE; only the dbg_* output registers hold.
REQ-032 SHALL register all dbg_* outputs; in RUN, an event in cycle N is visible on the outputs in cycle N+1.
REQ-033 SHALL make dbg_ctrl_state[1:0] always reflect the current state, even in FREEZE.

Reset
REQ-034 SHALL, while v_rst0=1 at a clock edge, set the FSM to RUN and zero the timestamp, pend, all counters, latencies, and all dbg_* outputs.
REQ-035 SHALL, when reset is applied with commands outstanding, discard them; later completions for those tags count as anomalies.

Verification
REQ-036 SHALL cover: issue tag 2 at ts=10, done tag 2 at ts=35 -> last latency=25, max=25, dbg_cmd_cnt=1, outstanding=0.
REQ-037 SHALL cover: done tag 5 with nothing pending, done_err=1 -> anomaly=1, ECC count=1, latencies unchanged.
REQ-038 SHALL cover: the same cycle issues and completes tag 1 (started at ts=100), now ts=140 -> last latency=40, pend[1]=1, start[1]=140, outstanding unchanged.
REQ-039 SHALL cover: freeze, then 3 issues, then unfreeze -> outputs hold during freeze, show dbg_cmd_cnt+3 the cycle after RUN resumes.
REQ-040 SHALL cover: issue 8 tags, pulse ctrl_clear -> one cycle of state=2, then all counters 0, outstanding 0, and later completions count as anomalies.
REQ-041 SHALL cover: force the cmd count to 0xFFFF, then issue -> dbg_cmd_cnt stays 0xFFFF; a timestamp wrap between issue and done still gives the correct latency.
